ram_ctrl: RTL and testbench
===========================

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, address width; DEPTH = 2^ADDR_WIDTH words (16).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  controller accepts request this cycle.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  ADDR_WIDTH  request address.
REQ-009 req_wdata  in  DATA_WIDTH  write data.
REQ-010 rsp_valid  out  1  read data available.
REQ-011 rsp_ready  in  1  consumer takes read data.
REQ-012 rsp_rdata  out  DATA_WIDTH  read data.
REQ-013 busy  out  1  post-reset memory clear in progress.
REQ-014 ram_we  out  1  write enable to single-port synchronous RAM.
REQ-015 ram_addr  out  ADDR_WIDTH  RAM address.
REQ-016 ram_din  out  DATA_WIDTH  RAM write data.
REQ-017 ram_dout  in  DATA_WIDTH  RAM registered read data, valid one cycle after address presented.

Function
REQ-018 States SHALL be CLEAR, IDLE, RD_ISSUE, RD_WAIT, RESP.
REQ-019 ram_we/ram_addr/ram_din SHALL be driven from registered state only; no combinational path from req_* or rsp_ready.
REQ-020 Accept SHALL occur on req_valid && req_ready.
REQ-021 CLEAR: ram_we=1, ram_addr=clear counter, ram_din=0, busy=1, req_ready=0; counter increments 0..DEPTH-1, one word per cycle.
REQ-022 CLEAR -> IDLE on the cycle after address DEPTH-1 is written; clear takes exactly DEPTH cycles after rst deasserts.
REQ-023 IDLE: req_ready=1, busy=0.
REQ-024 Write accepted in cycle T SHALL drive ram_we=1, ram_addr=req_addr, ram_din=req_wdata in T+1; state remains IDLE; no response generated.
REQ-025 Back-to-back writes SHALL sustain one per cycle.
REQ-026 In IDLE with no write issued from the previous cycle, ram_we=0; ram_addr and ram_din hold their last values.
REQ-027 Read accepted in T: T+1 = RD_ISSUE (ram_we=0, ram_addr=req_addr); T+2 = RD_WAIT (ram_dout captured into rsp_rdata at end of cycle); T+3 = RESP with rsp_valid=1.
REQ-028 req_ready SHALL be 0 in RD_ISSUE, RD_WAIT and RESP.
REQ-029 RESP: rsp_valid and rsp_rdata held stable until rsp_ready=1; on that edge rsp_valid -> 0 and state -> IDLE.
REQ-030 rsp_rdata SHALL retain the last read value after the handshake until the next capture.
REQ-031 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-032 A write accepted in the last IDLE cycle before a read SHALL still be issued to the RAM (in RD_ISSUE's preceding cycle) before the read address is presented.
REQ-033 Addresses SHALL be used modulo DEPTH; no out-of-range condition exists.

Reset
REQ-034 While rst=1: state=CLEAR, clear counter=0, ram_we=0, ram_addr=0, ram_din=0, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=1.
REQ-035 rst asserted in any state, including mid-clear or mid-read, SHALL abort the operation, discard pending response, and restart the full clear.
REQ-036 Requests presented while busy=1 SHALL NOT be accepted and SHALL have no effect.

Verification
REQ-037 Deassert rst -> ram_we=1 with addresses 0..15 and ram_din=0 on 16 consecutive cycles; busy=0 and req_ready=1 on cycle 16.
REQ-038 Write 0xA5 to addr 3, then read addr 3 the next cycle -> rsp_valid 3 cycles after the read is accepted, with rsp_rdata=0xA5.
REQ-039 Read addr 7 after clear, with no prior write -> rsp_rdata=0x00.
REQ-040 Read response with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; handshake on cycle 6, then IDLE.
REQ-041 Four back-to-back writes (addr 0..3 = 0x11..0x44) -> four consecutive ram_we=1 cycles; read-back returns each value.
REQ-042 Assert rst during RD_WAIT -> rsp_valid never asserts; full 16-cycle clear restarts.

Source files
------------

// File: rtl/ram_ctrl_if.sv
// Request/response and RAM-side bus of the RAM controller.
// slave is the controller's view; master is the requester plus the RAM.
interface ram_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  busy;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, busy, ram_we, ram_addr, ram_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, busy, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_ctrl.sv
// Controller for a single-port synchronous RAM: clears the whole memory after
// reset, then serves one-cycle writes and four-stage reads with a held response.
module ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    ram_ctrl_if.slave bus
);
    localparam logic [2:0] CLEAR    = 3'd0;
    localparam logic [2:0] IDLE     = 3'd1;
    localparam logic [2:0] RD_ISSUE = 3'd2;
    localparam logic [2:0] RD_WAIT  = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    logic [2:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q,   clr_cnt_d;
    logic                  ram_we_q,    ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q,   ram_din_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                // Leave the RAM bus showing the last cleared word so IDLE holds it.
                if (clr_cnt_q == '1) begin
                    state_d    = IDLE;
                    ram_addr_d = '1;
                    ram_din_d  = '0;
                end
            end
            IDLE: begin
                if (bus.req_valid) begin
                    ram_addr_d = bus.req_addr;
                    if (bus.req_we) begin
                        ram_we_d  = 1'b1;
                        ram_din_d = bus.req_wdata;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                rsp_rdata_d = bus.ram_dout;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Clear writes are gated only by rst, so word 0 is written in the very
    // first cycle after rst falls and the clear lasts exactly DEPTH cycles.
    assign bus.ram_we    = (state_q == CLEAR) ? ~rst      : ram_we_q;
    assign bus.ram_addr  = (state_q == CLEAR) ? clr_cnt_q : ram_addr_q;
    assign bus.ram_din   = (state_q == CLEAR) ? '0        : ram_din_q;

    assign bus.busy      = (state_q == CLEAR);
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_ram_ctrl.sv
// Randomized bench for ram_ctrl: models the RAM as the environment and checks
// every cycle against an array-based memory model plus expected bus values.
module tb_ram_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-port RAM with registered read; reset scribbles garbage into it.
    logic [DW-1:0] ramArray [DEPTH];
    always @(posedge clk) begin
        if (rst)
            ramArray[AW'($urandom)] <= DW'($urandom);
        else if (bus.ram_we)
            ramArray[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= ramArray[bus.ram_addr];
    end

    logic [DW-1:0] modelMem [DEPTH];
    logic          expWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expDin;
    logic [DW-1:0] expRdata;
    int            checkCount = 0;
    int            errorCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic we,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic rready);
        bus.req_valid = valid;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.rsp_ready = rready;
    endtask

    task automatic applyJunk(input logic rready);
        applyStimulus(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), rready);
    endtask

    task automatic toSample();
        @(negedge clk);
    endtask

    task automatic toDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle();
        checkOutput("idle_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("idle_busy",      32'(bus.busy),      32'd0);
        checkOutput("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("idle_rsp_rdata", 32'(bus.rsp_rdata), 32'(expRdata));
        checkOutput("idle_ram_we",    32'(bus.ram_we),    32'(expWe));
        checkOutput("idle_ram_addr",  32'(bus.ram_addr),  32'(expAddr));
        checkOutput("idle_ram_din",   32'(bus.ram_din),   32'(expDin));
    endtask

    task automatic checkBusyRead(input logic respExpected);
        checkOutput("rd_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rd_busy",      32'(bus.busy),      32'd0);
        checkOutput("rd_rsp_valid", 32'(bus.rsp_valid), 32'(respExpected));
        checkOutput("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'(expRdata));
        checkOutput("rd_ram_we",    32'(bus.ram_we),    32'd0);
        checkOutput("rd_ram_addr",  32'(bus.ram_addr),  32'(expAddr));
        checkOutput("rd_ram_din",   32'(bus.ram_din),   32'(expDin));
    endtask

    task automatic checkReset();
        checkOutput("rst_busy",      32'(bus.busy),      32'd1);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_ram_we",    32'(bus.ram_we),    32'd0);
        checkOutput("rst_ram_addr",  32'(bus.ram_addr),  32'd0);
        checkOutput("rst_ram_din",   32'(bus.ram_din),   32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    endtask

    task automatic holdReset(input int cycles);
        rst = 1'b1;
        applyJunk(1'($urandom));
        toDrive();
        for (int i = 0; i < cycles; i++) begin
            applyJunk(1'($urandom));
            toSample();
            checkReset();
            toDrive();
        end
        expRdata = '0;
    endtask

    // Requests thrown at the controller during the clear must be ignored.
    task automatic runClear();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            applyJunk(1'($urandom));
            toSample();
            checkOutput("clr_ram_we",    32'(bus.ram_we),    32'd1);
            checkOutput("clr_ram_addr",  32'(bus.ram_addr),  32'(i));
            checkOutput("clr_ram_din",   32'(bus.ram_din),   32'd0);
            checkOutput("clr_busy",      32'(bus.busy),      32'd1);
            checkOutput("clr_req_ready", 32'(bus.req_ready), 32'd0);
            checkOutput("clr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            toDrive();
        end
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
        expWe   = 1'b0;
        expAddr = AW'(DEPTH - 1);
        expDin  = '0;
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, 1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom));
        toSample();
        checkIdle();
        toDrive();
        expWe = 1'b0;
    endtask

    task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        applyStimulus(1'b1, 1'b1, addr, data, 1'($urandom));
        toSample();
        checkIdle();
        toDrive();
        modelMem[addr] = data;
        expWe   = 1'b1;
        expAddr = addr;
        expDin  = data;
    endtask

    task automatic acceptRead(input logic [AW-1:0] addr);
        applyStimulus(1'b1, 1'b0, addr, DW'($urandom), 1'($urandom));
        toSample();
        checkIdle();
        toDrive();
        expWe   = 1'b0;
        expAddr = addr;
    endtask

    task automatic doRead(input logic [AW-1:0] addr, input int stall);
        acceptRead(addr);
        for (int k = 0; k < 2; k++) begin
            applyJunk(1'($urandom));
            toSample();
            checkBusyRead(1'b0);
            toDrive();
        end
        expRdata = modelMem[addr];
        for (int s = 0; s < stall; s++) begin
            applyJunk(1'b0);
            toSample();
            checkBusyRead(1'b1);
            toDrive();
        end
        applyJunk(1'b1);
        toSample();
        checkBusyRead(1'b1);
        toDrive();
    endtask

    // Reset lands while the read sits in RD_WAIT; no response may appear.
    task automatic doReadAbort(input logic [AW-1:0] addr);
        acceptRead(addr);
        applyJunk(1'($urandom));
        toSample();
        checkBusyRead(1'b0);
        toDrive();
        holdReset(4);
        runClear();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        rst      = 1'b1;
        expWe    = 1'b0;
        expAddr  = '0;
        expDin   = '0;
        expRdata = '0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;

        holdReset(20);
        runClear();

        $display("[TB] directed: write/read same address, unwritten read, stall");
        doWrite(4'd3, 8'hA5);
        doRead(4'd3, 0);
        doRead(4'd7, 0);
        doRead(4'd3, 5);

        $display("[TB] directed: back-to-back writes and read-back");
        doWrite(4'd0, 8'h11);
        doWrite(4'd1, 8'h22);
        doWrite(4'd2, 8'h33);
        doWrite(4'd3, 8'h44);
        for (int a = 0; a < 4; a++) doRead(AW'(a), 1);
        doIdle();
        doIdle();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 250; n++) begin
            int sel;
            logic [AW-1:0] addr;
            sel  = int'($urandom_range(0, 9));
            addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            if (sel < 4)
                doWrite(addr, DW'($urandom));
            else if (sel < 7)
                doRead(addr, int'($urandom_range(0, 3)));
            else
                doIdle();
        end

        $display("[TB] reset during read wait");
        doWrite(4'd9, 8'h5C);
        doReadAbort(4'd9);
        doRead(4'd9, 0);
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 1) == 0)
                doWrite(AW'($urandom), DW'($urandom));
            else
                doRead(AW'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
